edp_mdsq: RTL and testbench

- Multiply/divide step sequencer for the EBOX data path (EDP).
- On `start`, it takes over the AD function, ADB select, AR/ARX load, MQM select and MQ shift-mode controls for a fixed run of shift-add (multiply) or non-restoring (divide) steps.
- It sits between CTL/CRAM decode and the EDP. It drives the datapath only while `busy`; otherwise the CRAM fields pass through.
- It detects divide overflow and signals completion with a one-cycle pulse.

---
 rtl/edp_mdsq_pkg.sv | 58 +++++
 rtl/edp_mdsq_step_cnt.sv | 41 ++++
 rtl/edp_mdsq.sv | 202 ++++++++++++++++++++
 tb/tb_edp_mdsq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edp_mdsq_pkg.sv
// Shared types and encodings for the EDP multiply/divide step sequencer.
//   mdsq_state_t : sequencer FSM states
//   AD_* / ADB_* : AD function and ADB select codes driven to the EDP
//   MQ_*         : MQ USR4 shift modes
//   mdsq_ctl_t   : registered datapath control bundle
package edp_mdsq_pkg;

    localparam int unsigned AD_W  = 6;
    localparam int unsigned ADB_W = 2;
    localparam int unsigned MQ_W  = 2;

    typedef enum logic [2:0] {
        MDSQ_IDLE  = 3'd0,
        MDSQ_SETUP = 3'd1,
        MDSQ_STEP  = 3'd2,
        MDSQ_FIXUP = 3'd3,
        MDSQ_DONE  = 3'd4
    } mdsq_state_t;

    localparam logic [AD_W-1:0]  AD_A         = 6'o25;
    localparam logic [AD_W-1:0]  AD_A_PLUS_B  = 6'o06;
    localparam logic [AD_W-1:0]  AD_A_MINUS_B = 6'o31;

    localparam logic [ADB_W-1:0] ADB_BR       = 2'b10;

    localparam logic [MQ_W-1:0]  MQ_HOLD      = 2'b00;
    localparam logic [MQ_W-1:0]  MQ_SHL       = 2'b01;
    localparam logic [MQ_W-1:0]  MQ_SHR       = 2'b10;
    localparam logic [MQ_W-1:0]  MQ_LOAD      = 2'b11;

    typedef struct packed {
        logic [AD_W-1:0]  ad;
        logic [ADB_W-1:0] adb;
        logic             ar;
        logic             arx;
        logic [MQ_W-1:0]  mqm;
        logic [MQ_W-1:0]  mq;
        logic             busy;
        logic             done;
    } mdsq_ctl_t;

    localparam mdsq_ctl_t CTL_IDLE = '{
        ad:   AD_A,
        adb:  ADB_BR,
        ar:   1'b0,
        arx:  1'b0,
        mqm:  2'b00,
        mq:   MQ_HOLD,
        busy: 1'b0,
        done: 1'b0
    };

    // Non-restoring divide: subtract while the running quotient bit is 1, else add back.
    function automatic logic [AD_W-1:0] div_ad_fn(input logic qb);
        return qb ? AD_A_MINUS_B : AD_A_PLUS_B;
    endfunction

endpackage

// File: rtl/edp_mdsq_step_cnt.sv
// Loadable down-counter with a registered zero flag; stops at zero (no wrap).
//   clk, reset   : clock, async active-high reset (count = 0, zero = 1)
//   load_i       : load load_val_i (has priority over dec_i)
//   dec_i        : decrement by one unless already zero
//   zero_o       : count is zero
module edp_mdsq_step_cnt #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_d;

    // Next count and its zero flag, so zero_o stays registered.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            zero_o <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_o <= zero_d;
        end
    end

endmodule

// File: rtl/edp_mdsq.sv
// EDP multiply/divide step sequencer. Takes over AD/ADB/AR/ARX/MQ controls
// for a fixed run of shift-add multiply or non-restoring divide steps.
//   clk, reset          : EDP clock, async active-high reset
//   start, op_div       : begin operation (IDLE only); 0 = multiply, 1 = divide
//   mq_lsb, ad_sign     : MQ[34:35] and AD sign feedback from the EDP
//   cram_ad, cram_adb   : microcode fields passed through while not busy
//   ad_fn, adb_sel      : AD function / ADB select to the EDP
//   ar_load, arx_load   : AR / ARX load strobes
//   mqm_sel, mq_sel     : MQM mux select, MQ shift mode
//   busy, done, div_ovf : datapath owned, completion pulse, sticky overflow
// Optional: define EDP_MDSQ_BOOTH_EN for radix-2 Booth-recoded multiply.
module edp_mdsq
    import edp_mdsq_pkg::*;
#(
    parameter int unsigned STEPS = 36,
    parameter int unsigned CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [1:0]       mq_lsb,
    input  logic             ad_sign,
    input  logic [AD_W-1:0]  cram_ad,
    input  logic [ADB_W-1:0] cram_adb,
    output logic [AD_W-1:0]  ad_fn,
    output logic [ADB_W-1:0] adb_sel,
    output logic             ar_load,
    output logic             arx_load,
    output logic [MQ_W-1:0]  mqm_sel,
    output logic [MQ_W-1:0]  mq_sel,
    output logic             busy,
    output logic             done,
    output logic             div_ovf
);

    mdsq_state_t     state_q, state_d;
    mdsq_ctl_t       ctl_q, ctl_d;
    logic            op_div_q, op_div_d;
    logic            qb_q, qb_d;
    logic            ovf_q, ovf_d;
    logic            cnt_load_c, cnt_dec_c, cnt_zero;
    logic [AD_W-1:0] mul_ad_c;
    logic            mq_lsb0_unused;

    // MQ34 is not needed for radix-2 recoding.
    assign mq_lsb0_unused = mq_lsb[0];

    edp_mdsq_step_cnt #(
        .W (CNTW)
    ) u_step_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_c),
        .load_val_i (CNTW'(STEPS - 1)),
        .dec_i      (cnt_dec_c),
        .zero_o     (cnt_zero)
    );

`ifdef EDP_MDSQ_BOOTH_EN
    logic prev_q;
    logic mul_issue_c;

    // Booth recode on {current LSB, previously consumed LSB}.
    always_comb begin
        mul_issue_c = !op_div_q &&
                      ((state_q == MDSQ_SETUP) || ((state_q == MDSQ_STEP) && !cnt_zero));
        case ({mq_lsb[1], prev_q})
            2'b10:   mul_ad_c = AD_A_MINUS_B;
            2'b01:   mul_ad_c = AD_A_PLUS_B;
            default: mul_ad_c = AD_A;
        endcase
    end

    // Held clear while idle so the first step sees prev = 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (state_q == MDSQ_IDLE) begin
            prev_q <= 1'b0;
        end else if (mul_issue_c) begin
            prev_q <= mq_lsb[1];
        end
    end
`else
    // Plain add-if-LSB multiply.
    always_comb begin
        mul_ad_c = mq_lsb[1] ? AD_A_PLUS_B : AD_A;
    end
`endif

    // Next state plus the control word for the cycle being entered.
    always_comb begin
        state_d    = state_q;
        op_div_d   = op_div_q;
        qb_d       = qb_q;
        ovf_d      = ovf_q;
        ctl_d      = CTL_IDLE;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        case (state_q)
            MDSQ_IDLE: begin
                if (start) begin
                    op_div_d   = op_div;
                    ovf_d      = 1'b0;
                    cnt_load_c = 1'b1;
                    state_d    = MDSQ_SETUP;
                    ctl_d.busy = 1'b1;
                    if (op_div) begin
                        ctl_d.ad = AD_A_MINUS_B;   // trial subtract, no load
                    end else begin
                        ctl_d.ad = AD_A;
                        ctl_d.ar = 1'b1;
                    end
                end
            end
            MDSQ_SETUP: begin
                ctl_d.busy = 1'b1;
                if (op_div_q) begin
                    if (!ad_sign) begin
                        // Quotient will not fit: drain through FIXUP with no loads.
                        ovf_d   = 1'b1;
                        state_d = MDSQ_FIXUP;
                    end else begin
                        qb_d     = 1'b1;
                        state_d  = MDSQ_STEP;
                        ctl_d.ad = AD_A_MINUS_B;
                        ctl_d.ar = 1'b1;
                        ctl_d.mq = MQ_SHL;
                    end
                end else begin
                    state_d   = MDSQ_STEP;
                    ctl_d.ad  = mul_ad_c;
                    ctl_d.ar  = 1'b1;
                    ctl_d.arx = 1'b1;
                    ctl_d.mq  = MQ_SHR;
                end
            end
            MDSQ_STEP: begin
                ctl_d.busy = 1'b1;
                cnt_dec_c  = !cnt_zero;
                if (op_div_q) begin
                    qb_d = ~ad_sign;
                end
                if (cnt_zero) begin
                    state_d = MDSQ_FIXUP;
                    if (op_div_q && !qb_d) begin
                        ctl_d.ad = AD_A_PLUS_B;    // restore remainder
                        ctl_d.ar = 1'b1;
                    end
                end else if (op_div_q) begin
                    ctl_d.ad = div_ad_fn(qb_d);
                    ctl_d.ar = 1'b1;
                    ctl_d.mq = MQ_SHL;
                end else begin
                    ctl_d.ad  = mul_ad_c;
                    ctl_d.ar  = 1'b1;
                    ctl_d.arx = 1'b1;
                    ctl_d.mq  = MQ_SHR;
                end
            end
            MDSQ_FIXUP: begin
                state_d    = MDSQ_DONE;
                ctl_d.done = 1'b1;
            end
            MDSQ_DONE: begin
                state_d = MDSQ_IDLE;
            end
            default: begin
                state_d = MDSQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MDSQ_IDLE;
            ctl_q    <= CTL_IDLE;
            op_div_q <= 1'b0;
            qb_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            op_div_q <= op_div_d;
            qb_q     <= qb_d;
            ovf_q    <= ovf_d;
        end
    end

    // CRAM fields reach the EDP directly whenever the sequencer is not driving.
    assign ad_fn    = ctl_q.busy ? ctl_q.ad  : cram_ad;
    assign adb_sel  = ctl_q.busy ? ctl_q.adb : cram_adb;
    assign ar_load  = ctl_q.ar;
    assign arx_load = ctl_q.arx;
    assign mqm_sel  = ctl_q.mqm;
    assign mq_sel   = ctl_q.mq;
    assign busy     = ctl_q.busy;
    assign done     = ctl_q.done;
    assign div_ovf  = ovf_q;

endmodule

// File: tb/tb_edp_mdsq.sv
// Bench for edp_mdsq: table of whole-operation vectors checked through a
// scoreboard queue, plus hand sequences for reset abort, held start and recoding.
module tb_edp_mdsq;
    import edp_mdsq_pkg::*;

    logic             clk;
    logic             reset;
    logic             start;
    logic             op_div;
    logic [1:0]       mq_lsb;
    logic             ad_sign;
    logic [AD_W-1:0]  cram_ad;
    logic [ADB_W-1:0] cram_adb;
    logic [AD_W-1:0]  ad_fn;
    logic [ADB_W-1:0] adb_sel;
    logic             ar_load;
    logic             arx_load;
    logic [MQ_W-1:0]  mqm_sel;
    logic [MQ_W-1:0]  mq_sel;
    logic             busy;
    logic             done;
    logic             div_ovf;

    edp_mdsq #(.STEPS(36), .CNTW(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_div   (op_div),
        .mq_lsb   (mq_lsb),
        .ad_sign  (ad_sign),
        .cram_ad  (cram_ad),
        .cram_adb (cram_adb),
        .ad_fn    (ad_fn),
        .adb_sel  (adb_sel),
        .ar_load  (ar_load),
        .arx_load (arx_load),
        .mqm_sel  (mqm_sel),
        .mq_sel   (mq_sel),
        .busy     (busy),
        .done     (done),
        .div_ovf  (div_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        op_div;
        int        mq_mode;
        int        sign_mode;
        int        lat;
        int        busy_n;
        int        steps;
        int        n_plus;
        int        n_minus;
        int        n_a;
        int        ar_n;
        bit        fix_ar;
        logic [5:0] setup_ad;
        bit        setup_ar;
        bit        ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] mq_pat(input int mode, input int c);
        case (mode)
            1:       return (c % 2 == 1) ? 2'b10 : 2'b00;
            2:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic sign_pat(input int mode, input int c);
        case (mode)
            1:       return 1'b1;
            2:       return (c == 1);
            3:       return (c == 1) ? 1'b1 : (c % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        vec_t       o, e;
        int         done_n, pt_err;
        bit         seen, first;
        logic       last_ar;
        logic [5:0] last_ad, fix_ad;
        logic [1:0] setup_adb;
        o.lat = -1; o.busy_n = 0; o.steps = 0; o.n_plus = 0; o.n_minus = 0;
        o.n_a = 0; o.ar_n = 0; o.fix_ar = 0; o.setup_ad = '0; o.setup_ar = 0; o.ovf = 0;
        done_n = 0; pt_err = 0; seen = 0; first = 1; last_ar = 0; last_ad = '0;
        fix_ad = '0; setup_adb = '0;
        exp_q.push_back(v);
        op_div   = v.op_div;
        start    = 1'b1;
        mq_lsb   = mq_pat(v.mq_mode, 0);
        ad_sign  = sign_pat(v.sign_mode, 0);
        cram_ad  = 6'($urandom);
        cram_adb = 2'($urandom);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) begin
                o.busy_n++;
                if (first) begin
                    first      = 0;
                    o.setup_ad = ad_fn;
                    o.setup_ar = ar_load;
                    setup_adb  = adb_sel;
                end
                if (mq_sel != MQ_HOLD) begin
                    o.steps++;
                    if (ad_fn == AD_A_PLUS_B) o.n_plus++;
                    else if (ad_fn == AD_A_MINUS_B) o.n_minus++;
                    else if (ad_fn == AD_A) o.n_a++;
                end
                if (ar_load) o.ar_n++;
                last_ar = ar_load;
                last_ad = ad_fn;
            end else if (ad_fn !== cram_ad || adb_sel !== cram_adb) begin
                pt_err++;
            end
            if (mqm_sel !== 2'b00) pt_err++;
            if (done) begin
                done_n++;
                if (!seen) begin
                    seen     = 1;
                    o.lat    = k;
                    o.ovf    = div_ovf;
                    o.fix_ar = last_ar;
                    fix_ad   = last_ad;
                end
            end
            if (seen && k >= o.lat + 2) break;
            mq_lsb   = mq_pat(v.mq_mode, k);
            ad_sign  = sign_pat(v.sign_mode, k);
            cram_ad  = 6'($urandom);
            cram_adb = 2'($urandom);
        end
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " latency"}, o.lat, e.lat);
            chk({tag, " busy_cycles"}, o.busy_n, e.busy_n);
            chk({tag, " steps"}, o.steps, e.steps);
            chk({tag, " n_plus"}, o.n_plus, e.n_plus);
            chk({tag, " n_minus"}, o.n_minus, e.n_minus);
            chk({tag, " n_a"}, o.n_a, e.n_a);
            chk({tag, " ar_loads"}, o.ar_n, e.ar_n);
            chk({tag, " fixup_ar"}, o.fix_ar, e.fix_ar);
            if (e.fix_ar) chk({tag, " fixup_ad"}, fix_ad, AD_A_PLUS_B);
            chk({tag, " setup_ad"}, o.setup_ad, e.setup_ad);
            chk({tag, " setup_ar"}, o.setup_ar, e.setup_ar);
            if (e.op_div) chk({tag, " setup_adb"}, setup_adb, ADB_BR);
            chk({tag, " div_ovf"}, o.ovf, e.ovf);
            chk({tag, " done_pulses"}, done_n, 1);
            chk({tag, " passthrough"}, pt_err, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " div_ovf"}, div_ovf, 0);
        chk({tag, " ar_load"}, ar_load, 0);
        chk({tag, " arx_load"}, arx_load, 0);
        chk({tag, " mq_sel"}, mq_sel, MQ_HOLD);
        chk({tag, " mqm_sel"}, mqm_sel, 0);
        chk({tag, " ad_pass"}, ad_fn, cram_ad);
        chk({tag, " adb_pass"}, adb_sel, cram_adb);
    endtask

    initial begin
        int         done_n, busy_n, first_done, second_done;
        logic       busy40, busy41;
        logic [5:0] bs_exp[3];
        logic [5:0] bs_act[3];

        vecs[0] = '{op_div:0, mq_mode:1, sign_mode:1, lat:39, busy_n:38, steps:36,
`ifdef EDP_MDSQ_BOOTH_EN
                    n_plus:18, n_minus:18, n_a:0,
`else
                    n_plus:18, n_minus:0, n_a:18,
`endif
                    ar_n:37, fix_ar:0, setup_ad:AD_A, setup_ar:1, ovf:0};
        vecs[1] = '{op_div:0, mq_mode:0, sign_mode:0, lat:39, busy_n:38, steps:36,
                    n_plus:0, n_minus:0, n_a:36,
                    ar_n:37, fix_ar:0, setup_ad:AD_A, setup_ar:1, ovf:0};
        vecs[2] = '{op_div:0, mq_mode:2, sign_mode:1, lat:39, busy_n:38, steps:36,
`ifdef EDP_MDSQ_BOOTH_EN
                    n_plus:0, n_minus:1, n_a:35,
`else
                    n_plus:36, n_minus:0, n_a:0,
`endif
                    ar_n:37, fix_ar:0, setup_ad:AD_A, setup_ar:1, ovf:0};
        vecs[3] = '{op_div:1, mq_mode:0, sign_mode:0, lat:3, busy_n:2, steps:0,
                    n_plus:0, n_minus:0, n_a:0,
                    ar_n:0, fix_ar:0, setup_ad:AD_A_MINUS_B, setup_ar:0, ovf:1};
        vecs[4] = '{op_div:1, mq_mode:1, sign_mode:1, lat:39, busy_n:38, steps:36,
                    n_plus:35, n_minus:1, n_a:0,
                    ar_n:37, fix_ar:1, setup_ad:AD_A_MINUS_B, setup_ar:0, ovf:0};
        vecs[5] = '{op_div:1, mq_mode:0, sign_mode:2, lat:39, busy_n:38, steps:36,
                    n_plus:0, n_minus:36, n_a:0,
                    ar_n:36, fix_ar:0, setup_ad:AD_A_MINUS_B, setup_ar:0, ovf:0};
        vecs[6] = '{op_div:1, mq_mode:2, sign_mode:3, lat:39, busy_n:38, steps:36,
                    n_plus:18, n_minus:18, n_a:0,
                    ar_n:36, fix_ar:0, setup_ad:AD_A_MINUS_B, setup_ar:0, ovf:0};

        reset = 1'b1; start = 1'b0; op_div = 1'b0; mq_lsb = 2'b00; ad_sign = 1'b0;
        cram_ad = 6'o17; cram_adb = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while stepping: counter is 17 in cycle 20 after start.
        op_div = 1'b0; start = 1'b1; mq_lsb = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("abort in_step", mq_sel, MQ_SHR);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        chk("abort no_done", done_n, 0);
        chk("abort no_busy", busy_n, 0);
        run_op(vecs[0], "rerun");

        // start held high across a whole operation.
        op_div = 1'b0; start = 1'b1; mq_lsb = 2'b00; ad_sign = 1'b0;
        done_n = 0; first_done = -1; second_done = -1; busy40 = 1'bx; busy41 = 1'bx;
        for (int k = 1; k <= 85; k++) begin
            @(posedge clk); #1;
            if (k == 60) start = 1'b0;
            if (k == 40) busy40 = busy;
            if (k == 41) busy41 = busy;
            if (done) begin
                done_n++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        chk("held first_done", first_done, 39);
        chk("held idle_gap", busy40, 0);
        chk("held restart", busy41, 1);
        chk("held second_done", second_done, 79);
        chk("held done_count", done_n, 2);

        // mq_lsb[1] = 1,1,0 over the first three step decisions.
`ifdef EDP_MDSQ_BOOTH_EN
        bs_exp[0] = AD_A_MINUS_B; bs_exp[1] = AD_A; bs_exp[2] = AD_A_PLUS_B;
`else
        bs_exp[0] = AD_A_PLUS_B; bs_exp[1] = AD_A_PLUS_B; bs_exp[2] = AD_A;
`endif
        op_div = 1'b0; start = 1'b1; mq_lsb = 2'b00;
        done_n = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k >= 2 && k <= 4) bs_act[k-2] = ad_fn;
            if (done) done_n++;
            if (k == 1 || k == 2) mq_lsb = 2'b10;
            else mq_lsb = 2'b00;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("recode step%0d", i), bs_act[i], bs_exp[i]);
        end
        chk("recode done", done_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
